// File: rtl/fft_disp_pkg.sv
// Shared definitions for the FFT lab display block.
//   - display mode codes (also driven straight onto led[1:0])
//   - timer FSM state type
//   - seg7_enc : hex nibble to active-low abcdefgh segment code
//   - bcd_inc  : single BCD digit increment, returns {carry, digit}
//   - to_bcd   : elaboration-time binary to packed BCD (up to 8 digits)
package fft_disp_pkg;

  localparam logic [1:0] MODE_BLANK    = 2'b00;
  localparam logic [1:0] MODE_TIME     = 2'b01;
  localparam logic [1:0] MODE_PEAK_BIN = 2'b10;
  localparam logic [1:0] MODE_PEAK_MAG = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tmr_state_e;

  function automatic logic [7:0] seg7_enc(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'h03;
      4'h1: s = 8'h9f;
      4'h2: s = 8'h25;
      4'h3: s = 8'h0d;
      4'h4: s = 8'h99;
      4'h5: s = 8'h49;
      4'h6: s = 8'h41;
      4'h7: s = 8'h1f;
      4'h8: s = 8'h01;
      4'h9: s = 8'h09;
      4'ha: s = 8'h11;
      4'hb: s = 8'hc1;
      4'hc: s = 8'h63;
      4'hd: s = 8'h85;
      4'he: s = 8'h61;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

  function automatic logic [4:0] bcd_inc(input logic [3:0] d);
    if (d >= 4'd9) return 5'b1_0000;
    return {1'b0, d + 4'd1};
  endfunction

  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] res;
    int unsigned rem;
    res = '0;
    rem = v;
    for (int k = 0; k < 8; k++) begin
      res[4*k +: 4] = 4'(rem % 10);
      rem = rem / 10;
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD up-counter.
//   clk, rst   : clock, async active-high reset
//   clr        : synchronous clear, wins over inc
//   inc        : add one (wraps 99..9 -> 00..0; callers gate inc to saturate)
//   digits     : packed BCD value, digit 0 in bits [3:0]
//   all_nines  : every digit is 9
module bcd_counter
  import fft_disp_pkg::*;
#(
  parameter int N_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  inc,
  output logic [4*N_DIGITS-1:0] digits,
  output logic                  all_nines
);

  logic [4*N_DIGITS-1:0] r_digits;
  logic [4*N_DIGITS-1:0] w_next;
  logic [4:0]            w_dig_inc;
  logic                  w_carry;
  logic                  w_all_nines;

  // Ripple the carry from digit 0 upward.
  always_comb begin
    w_next      = r_digits;
    w_carry     = inc;
    w_all_nines = 1'b1;
    w_dig_inc   = '0;
    for (int d = 0; d < N_DIGITS; d++) begin
      w_dig_inc = bcd_inc(r_digits[4*d +: 4]);
      if (w_carry) w_next[4*d +: 4] = w_dig_inc[3:0];
      w_carry = w_carry & w_dig_inc[4];
      if (r_digits[4*d +: 4] != 4'd9) w_all_nines = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      r_digits <= '0;
    else if (clr) r_digits <= '0;
    else if (inc) r_digits <= w_next;
  end

  assign digits    = r_digits;
  assign all_nines = w_all_nines;

endmodule

// File: rtl/fft_peak_display.sv
// Display and measurement block behind the sequential FFT core.
//   clk, rst          : clock, async active-high reset
//   key[1:0]          : raw active-low mode buttons (asynchronous)
//   en_fft            : frame start pulse (clears timer and peak state)
//   finish_fft        : frame end pulse (stops timer)
//   en_comp           : re_in/im_in hold one output bin
//   re_in, im_in      : signed FFT output sample
//   hex               : active-low 7-seg bank, digit d on hex[8d+7:8d]
//   led               : [1:0] mode, [2] frame complete, [3] timer overflow
//   busy              : timer running
//
// Timer FSM
//   state   | meaning
//   ST_IDLE | timer frozen, waiting for en_fft
//   ST_RUN  | timer counting every cycle until finish_fft
module fft_peak_display
  import fft_disp_pkg::*;
#(
  parameter int BIT_WIDTH = 34,
  parameter int N         = 32,
  parameter int MAG_BITS  = 8,
  parameter int N_DIGITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            key,
  input  logic                  en_fft,
  input  logic                  finish_fft,
  input  logic                  en_comp,
  input  logic [BIT_WIDTH-1:0]  re_in,
  input  logic [BIT_WIDTH-1:0]  im_in,
  output logic [8*N_DIGITS-1:0] hex,
  output logic [3:0]            led,
  output logic                  busy
);

  localparam int MW = 2*MAG_BITS + 1;
  localparam int DW = 4*N_DIGITS;
  localparam logic [31:0] BCD_LAST = to_bcd(N - 1);

  tmr_state_e            r_state;
  logic                  r_busy;
  logic                  r_ovf;
  logic                  r_frame_done;
  logic [MW-1:0]         r_amax;
  logic [DW-1:0]         r_peak_bin;
  logic [1:0]            r_key_s1, r_key_s2;
  logic [1:0]            r_mode;
  logic [8*N_DIGITS-1:0] r_hex;

  logic [DW-1:0] w_tmr_digits, w_bin_cnt, w_last_bin, w_nib;
  logic          w_tmr_nines, w_bin_nines, w_tmr_inc, w_bin_inc;
  logic signed [MAG_BITS-1:0]   w_re_top, w_im_top;
  logic signed [2*MAG_BITS-1:0] w_re_sq, w_im_sq;
  logic [MW-1:0]                w_mag;
  logic [MW+DW-1:0]             w_amax_ext;
  logic                         w_unused;

  // Timer saturates: stop incrementing once every digit is 9.
  assign w_tmr_inc = (r_state == ST_RUN) && !en_fft && !w_tmr_nines;
  assign w_bin_inc = en_comp && !en_fft && !r_frame_done;

  bcd_counter #(.N_DIGITS(N_DIGITS)) u_timer (
    .clk(clk), .rst(rst), .clr(en_fft), .inc(w_tmr_inc),
    .digits(w_tmr_digits), .all_nines(w_tmr_nines)
  );

  bcd_counter #(.N_DIGITS(N_DIGITS)) u_bin_cnt (
    .clk(clk), .rst(rst), .clr(en_fft), .inc(w_bin_inc),
    .digits(w_bin_cnt), .all_nines(w_bin_nines)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en_fft) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
            r_ovf   <= 1'b0;
          end
        end
        ST_RUN: begin
          if (en_fft) begin
            r_ovf <= 1'b0;
          end else begin
            if (w_tmr_nines) r_ovf <= 1'b1;
            if (finish_fft) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Squares of signed operands are non-negative, so a zero-extended sum
  // of MW bits holds the -128/-128 corner without overflow.
  assign w_re_top = re_in[BIT_WIDTH-1 -: MAG_BITS];
  assign w_im_top = im_in[BIT_WIDTH-1 -: MAG_BITS];
  assign w_re_sq  = w_re_top * w_re_top;
  assign w_im_sq  = w_im_top * w_im_top;
  assign w_mag    = {1'b0, w_re_sq} + {1'b0, w_im_sq};
  assign w_last_bin = BCD_LAST[DW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_amax       <= '0;
      r_peak_bin   <= '0;
      r_frame_done <= 1'b0;
    end else if (en_fft) begin
      r_amax       <= '0;
      r_peak_bin   <= '0;
      r_frame_done <= 1'b0;
    end else if (w_bin_inc) begin
      if (w_mag > r_amax) begin
        r_amax     <= w_mag;
        r_peak_bin <= w_bin_cnt;
      end
      if (w_bin_cnt == w_last_bin) r_frame_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_s1 <= 2'b00;
      r_key_s2 <= 2'b00;
      r_mode   <= MODE_BLANK;
    end else begin
      r_key_s1 <= key;
      r_key_s2 <= r_key_s1;
      case (r_key_s2)
        2'b11:   r_mode <= MODE_TIME;
        2'b01:   r_mode <= MODE_PEAK_BIN;
        2'b10:   r_mode <= MODE_PEAK_MAG;
        default: r_mode <= MODE_BLANK;
      endcase
    end
  end

  // Any amax bits above the displayable nibbles force an all-F readout.
  assign w_amax_ext = {{DW{1'b0}}, r_amax};

  always_comb begin
    w_nib = '0;
    case (r_mode)
      MODE_TIME:     w_nib = w_tmr_digits;
      MODE_PEAK_BIN: w_nib = r_peak_bin;
      MODE_PEAK_MAG: w_nib = (|w_amax_ext[MW+DW-1:DW]) ? {DW{1'b1}} : w_amax_ext[DW-1:0];
      default:       w_nib = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hex <= {N_DIGITS{8'h03}};
    end else begin
      for (int d = 0; d < N_DIGITS; d++) r_hex[8*d +: 8] <= seg7_enc(w_nib[4*d +: 4]);
    end
  end

  assign hex  = r_hex;
  assign led  = {r_ovf, r_frame_done, r_mode};
  assign busy = r_busy;

  assign w_unused = ^{re_in[BIT_WIDTH-MAG_BITS-1:0], im_in[BIT_WIDTH-MAG_BITS-1:0], w_bin_nines};

endmodule

// File: tb/tb_fft_peak_display.sv
module tb_fft_peak_display;

  localparam int BW = 34;
  localparam int N  = 32;
  localparam int MB = 8;
  localparam int ND = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    key;
  logic          en_fft, finish_fft, en_comp;
  logic [BW-1:0] re_in, im_in;
  logic [8*ND-1:0] hex;
  logic [3:0]    led;
  logic          busy;

  always #5 clk = ~clk;

  fft_peak_display #(.BIT_WIDTH(BW), .N(N), .MAG_BITS(MB), .N_DIGITS(ND)) dut (
    .clk(clk), .rst(rst), .key(key), .en_fft(en_fft), .finish_fft(finish_fft),
    .en_comp(en_comp), .re_in(re_in), .im_in(im_in), .hex(hex), .led(led), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain integers following the block's rules.
  int   m_timer, m_bins, m_amax, m_peak;
  bit   m_run, m_ovf, m_done;
  logic [1:0] m_s1, m_s2, m_mode;
  logic [8*ND-1:0] exp_hex;

  function automatic logic [7:0] seg(input int v);
    case (v)
      0: return 8'h03;  1: return 8'h9f;  2: return 8'h25;  3: return 8'h0d;
      4: return 8'h99;  5: return 8'h49;  6: return 8'h41;  7: return 8'h1f;
      8: return 8'h01;  9: return 8'h09;  10: return 8'h11; 11: return 8'hc1;
      12: return 8'h63; 13: return 8'h85; 14: return 8'h61; default: return 8'h71;
    endcase
  endfunction

  function automatic logic [8*ND-1:0] disp(input logic [1:0] mode, input int t, input int p, input int a);
    logic [8*ND-1:0] h;
    int nib;
    h = '0;
    for (int d = 0; d < ND; d++) begin
      case (mode)
        2'b01:   nib = (t / (10**d)) % 10;
        2'b10:   nib = (p / (10**d)) % 10;
        2'b11:   nib = (a >= 16**ND) ? 15 : ((a >> (4*d)) & 15);
        default: nib = 0;
      endcase
      h[8*d +: 8] = seg(nib);
    end
    return h;
  endfunction

  function automatic logic [1:0] key_mode(input logic [1:0] k);
    case (k)
      2'b11:   return 2'b01;
      2'b01:   return 2'b10;
      2'b10:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic int mag_of(input logic [BW-1:0] re, input logic [BW-1:0] im);
    int r, i;
    r = int'($signed(re[BW-1 -: MB]));
    i = int'($signed(im[BW-1 -: MB]));
    return r*r + i*i;
  endfunction

  task automatic model_reset();
    m_timer = 0; m_bins = 0; m_amax = 0; m_peak = 0;
    m_run = 0; m_ovf = 0; m_done = 0;
    m_s1 = 2'b00; m_s2 = 2'b00; m_mode = 2'b00;
  endtask

  task automatic model_update();
    int mg;
    if (en_fft) begin
      m_timer = 0; m_run = 1; m_ovf = 0;
      m_bins = 0; m_amax = 0; m_peak = 0; m_done = 0;
    end else begin
      if (m_run) begin
        if (m_timer == 9999) m_ovf = 1;
        else m_timer++;
        if (finish_fft) m_run = 0;
      end
      if (en_comp && m_bins < N) begin
        mg = mag_of(re_in, im_in);
        if (mg > m_amax) begin
          m_amax = mg;
          m_peak = m_bins;
        end
        m_bins++;
        if (m_bins == N) m_done = 1;
      end
    end
    m_mode = key_mode(m_s2);
    m_s2 = m_s1;
    m_s1 = key;
  endtask

  // One clock: hex after the edge reflects the state before it.
  task automatic step();
    exp_hex = disp(m_mode, m_timer, m_peak, m_amax);
    @(posedge clk);
    model_update();
    #1;
    en_fft = 0; finish_fft = 0; en_comp = 0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic set_sample(input int r, input int i);
    re_in = {r[7:0], 26'($urandom)};
    im_in = {i[7:0], 26'($urandom)};
  endtask

  function automatic int small_val();
    return int'($urandom_range(0, 10)) - 5;
  endfunction

  task automatic test_reset();
    rst = 1; key = 2'b00; en_fft = 0; finish_fft = 0; en_comp = 0;
    re_in = '0; im_in = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (hex !== 32'h03030303) begin n_errors++; $display("FAIL reset_hex: got %h want %h", hex, 32'h03030303); end
    n_checks++; if (led !== 4'b0000) begin n_errors++; $display("FAIL reset_led: got %b want 0000", led); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    model_reset();
    rst = 0;
  endtask

  task automatic test_timer();
    int len;
    key = 2'b11; idle(5);
    en_fft = 1; step();
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL timer_busy_run: got %b want 1", busy); end
    idle(136);
    finish_fft = 1; step();
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL timer_busy_done: got %b want 0", busy); end
    n_checks++; if (led !== 4'b0001) begin n_errors++; $display("FAIL timer_led: got %b want 0001", led); end
    step();
    n_checks++; if (hex !== 32'h039f0d1f) begin n_errors++; $display("FAIL timer_137: got %h want %h", hex, 32'h039f0d1f); end
    for (int it = 0; it < 4; it++) begin
      len = $urandom_range(1, 400);
      en_fft = 1; step();
      if (it == 2) begin
        idle(len / 2);
        en_fft = 1; step();
      end
      idle(len - 1);
      finish_fft = 1; step();
      step();
      n_checks++; if (hex !== exp_hex) begin n_errors++; $display("FAIL timer_rand len=%0d: got %h want %h", len, hex, exp_hex); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL timer_rand_busy: got %b want 0", busy); end
    end
  endtask

  task automatic test_saturation();
    en_fft = 1; step();
    idle(10050);
    n_checks++; if (hex !== 32'h09090909) begin n_errors++; $display("FAIL sat_hex: got %h want %h", hex, 32'h09090909); end
    n_checks++; if (led !== {m_ovf, m_done, m_mode} || led[3] !== 1'b1) begin n_errors++; $display("FAIL sat_led: got %b want 1%b%b", led, m_done, m_mode); end
    en_fft = 1; step();
    n_checks++; if (led[3] !== 1'b0) begin n_errors++; $display("FAIL sat_clear: led3 got %b want 0", led[3]); end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL sat_restart_busy: got %b want 1", busy); end
    finish_fft = 1; step();
    idle(2);
  endtask

  task automatic test_peak();
    key = 2'b01; idle(5);
    en_fft = 1; step();
    for (int b = 0; b < N; b++) begin
      en_comp = 1;
      if (b == 5) set_sample(-128, -128);
      else set_sample(small_val(), small_val());
      step();
    end
    step();
    n_checks++; if (hex !== 32'h03030349 || hex !== exp_hex) begin n_errors++; $display("FAIL peak_bin5: got %h want %h", hex, 32'h03030349); end
    n_checks++; if (led[2] !== 1'b1) begin n_errors++; $display("FAIL peak_done: got %b want 1", led[2]); end
    key = 2'b10; idle(5);
    n_checks++; if (hex !== 32'h01030303) begin n_errors++; $display("FAIL peak_mag8000: got %h want %h", hex, 32'h01030303); end
    // random frames with gaps between samples
    for (int f = 0; f < 3; f++) begin
      en_fft = 1; step();
      while (m_bins < N) begin
        if ($urandom_range(0, 3) != 0) begin
          en_comp = 1;
          set_sample(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
        end
        step();
      end
      key = 2'b01; idle(5);
      n_checks++; if (hex !== exp_hex) begin n_errors++; $display("FAIL rand_frame_bin f=%0d: got %h want %h", f, hex, exp_hex); end
      key = 2'b10; idle(5);
      n_checks++; if (hex !== exp_hex) begin n_errors++; $display("FAIL rand_frame_mag f=%0d: got %h want %h", f, hex, exp_hex); end
      n_checks++; if (led !== {m_ovf, m_done, m_mode}) begin n_errors++; $display("FAIL rand_frame_led f=%0d: got %b want %b%b%b", f, led, m_ovf, m_done, m_mode); end
    end
  endtask

  task automatic test_equal_max();
    key = 2'b01; idle(5);
    en_fft = 1; step();
    for (int b = 0; b < N; b++) begin
      en_comp = 1;
      if (b == 3) set_sample(100, 0);
      else if (b == 17) set_sample(0, -100);
      else set_sample(small_val(), small_val());
      step();
    end
    en_comp = 1; set_sample(-128, -128); step();
    step();
    n_checks++; if (hex !== 32'h0303030d || hex !== exp_hex) begin n_errors++; $display("FAIL eqmax_bin: got %h want %h", hex, 32'h0303030d); end
    key = 2'b10; idle(5);
    n_checks++; if (hex !== 32'h251f9f03) begin n_errors++; $display("FAIL eqmax_mag: got %h want %h", hex, 32'h251f9f03); end
  endtask

  task automatic test_back_to_back();
    key = 2'b11; idle(5);
    en_fft = 1; step();
    idle(3);
    en_fft = 1; finish_fft = 1; step();
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL collide_busy: got %b want 1", busy); end
    step();
    n_checks++; if (hex !== 32'h03030303) begin n_errors++; $display("FAIL collide_timer0: got %h want %h", hex, 32'h03030303); end
    step();
    n_checks++; if (hex !== exp_hex) begin n_errors++; $display("FAIL collide_timer1: got %h want %h", hex, exp_hex); end
    key = 2'b10; idle(5);
    en_fft = 1; en_comp = 1; set_sample(-128, -128); step();
    idle(2);
    n_checks++; if (hex !== 32'h03030303) begin n_errors++; $display("FAIL comp_with_fft: got %h want %h", hex, 32'h03030303); end
    for (int b = 0; b < N - 1; b++) begin
      en_comp = 1; set_sample(small_val(), small_val()); step();
    end
    n_checks++; if (led[2] !== 1'b0) begin n_errors++; $display("FAIL bins_31: done got %b want 0", led[2]); end
    en_comp = 1; set_sample(small_val(), small_val()); step();
    n_checks++; if (led[2] !== 1'b1) begin n_errors++; $display("FAIL bins_32: done got %b want 1", led[2]); end
    finish_fft = 1; step();
  endtask

  task automatic test_key_latency();
    key = 2'b11; idle(5);
    en_fft = 1; step();
    idle(50);
    key = 2'b01;
    idle(3);
    n_checks++; if (hex !== exp_hex || hex !== disp(2'b01, m_timer - 1, 0, 0)) begin n_errors++; $display("FAIL key_lat3: got %h want %h", hex, exp_hex); end
    step();
    n_checks++; if (hex !== exp_hex || hex !== disp(2'b10, 0, m_peak, 0)) begin n_errors++; $display("FAIL key_lat4: got %h want %h", hex, exp_hex); end
  endtask

  task automatic test_reset_mid();
    key = 2'b11; idle(5);
    en_fft = 1; step();
    idle(20);
    @(posedge clk);
    #3 rst = 1;
    #1;
    n_checks++; if (hex !== 32'h03030303) begin n_errors++; $display("FAIL rstmid_hex: got %h want %h", hex, 32'h03030303); end
    n_checks++; if (led !== 4'b0000) begin n_errors++; $display("FAIL rstmid_led: got %b want 0000", led); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    idle(5);
    en_fft = 1; step();
    idle(19);
    finish_fft = 1; step();
    step();
    n_checks++; if (hex !== 32'h03032503 || hex !== exp_hex) begin n_errors++; $display("FAIL rstmid_restart: got %h want %h", hex, 32'h03032503); end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_timer();
    test_saturation();
    test_peak();
    test_equal_max();
    test_back_to_back();
    test_key_latency();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
